// File: rtl/ddr_cmn_zqcal_ctrl.sv
// ddr_cmn_zqcal_ctrl
// ------------------
// ZQ calibration controller for the DDR common block. A start edge runs a
// successive-approximation search over the pull-down driver code, then
// over the pull-up driver code. Each trial bit is judged by the
// synchronised analog ZQ comparator output.
//
// Optional build macro: DDR_ZQCAL_MAJORITY_EN
//   When defined, every bit decision is the majority of three consecutive
//   synchronised comparator samples. Each sample phase is then 3 cycles.
//   When undefined, one sample is used per bit.
//
// Ports:
//   i_hclk        CSR/AHB clock (only clock)
//   i_hreset      asynchronous active-high reset
//   i_cal_en      calibration enable; low aborts a running calibration
//   i_cal_start   start request; only a rising edge is acted on
//   i_settle_cyc  settle cycles after each trial code (minimum 2 enforced)
//   i_comp        analog comparator output (asynchronous)
//   o_cal_active  enables the analog comparator/reference while busy
//   o_sel_pu      0 = pull-down phase, 1 = pull-up phase
//   o_pd_code     pull-down driver code
//   o_pu_code     pull-up driver code
//   o_sta         {error, done, busy, pu_code, pd_code}
module ddr_cmn_zqcal_ctrl #(
    parameter int CODE_W   = 6,
    parameter int SETTLE_W = 8
) (
    input  logic                  i_hclk,
    input  logic                  i_hreset,
    input  logic                  i_cal_en,
    input  logic                  i_cal_start,
    input  logic [SETTLE_W-1:0]   i_settle_cyc,
    input  logic                  i_comp,
    output logic                  o_cal_active,
    output logic                  o_sel_pu,
    output logic [CODE_W-1:0]     o_pd_code,
    output logic [CODE_W-1:0]     o_pu_code,
    output logic [2*CODE_W+2:0]   o_sta
);

    localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [IDX_W-1:0]  IDX_MSB  = IDX_W'(CODE_W - 1);
    localparam logic [CODE_W-1:0] CODE_MID = {1'b1, {(CODE_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PD_SET  = 3'd1,
        ST_PD_WAIT = 3'd2,
        ST_PD_SAMP = 3'd3,
        ST_PU_SET  = 3'd4,
        ST_PU_WAIT = 3'd5,
        ST_PU_SAMP = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    // A code pinned at either rail means the search never found a crossing.
    function automatic logic code_saturated(input logic [CODE_W-1:0] code);
        code_saturated = (&code) | (~|code);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        maj3 = (a & b) | (a & c) | (b & c);
    endfunction

    state_t                 state_r;
    logic [IDX_W-1:0]       idx_r;
    logic [SETTLE_W-1:0]    cnt_r;
    logic [CODE_W-1:0]      pd_code_r;
    logic [CODE_W-1:0]      pu_code_r;
    logic                   busy_r;
    logic                   sel_pu_r;
    logic                   done_r;
    logic                   error_r;
    logic                   start_q_r;
    logic                   comp_meta_r;
    logic                   comp_sync_r;

    logic                   start_edge_s;
    logic [SETTLE_W-1:0]    cnt_load_s;
    logic                   bit_ready_s;
    logic                   bit_dec_s;

    // Two-flop synchroniser for the comparator and the start-request delay.
    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            comp_meta_r <= 1'b0;
            comp_sync_r <= 1'b0;
            start_q_r   <= 1'b0;
        end else begin
            comp_meta_r <= i_comp;
            comp_sync_r <= comp_meta_r;
            start_q_r   <= i_cal_start;
        end
    end

    // Start edge detection and the settle reload value.
    // The reload value is clamped to at least 2 cycles so the synchroniser latency is covered.
    always_comb begin
        start_edge_s = i_cal_start & ~start_q_r & i_cal_en;
        if (i_settle_cyc < SETTLE_W'(2)) begin
            cnt_load_s = SETTLE_W'(1);
        end else begin
            cnt_load_s = i_settle_cyc - SETTLE_W'(1);
        end
    end

`ifdef DDR_ZQCAL_MAJORITY_EN
    logic [1:0] samp_cnt_r;
    logic       samp0_r;
    logic       samp1_r;

    // Collect the first two comparator samples of each sample phase.
    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            samp_cnt_r <= 2'd0;
            samp0_r    <= 1'b0;
            samp1_r    <= 1'b0;
        end else if ((state_r == ST_PD_SAMP || state_r == ST_PU_SAMP) && i_cal_en) begin
            if (samp_cnt_r == 2'd0) begin
                samp0_r    <= comp_sync_r;
                samp_cnt_r <= 2'd1;
            end else if (samp_cnt_r == 2'd1) begin
                samp1_r    <= comp_sync_r;
                samp_cnt_r <= 2'd2;
            end else begin
                samp_cnt_r <= 2'd0;
            end
        end else begin
            samp_cnt_r <= 2'd0;
        end
    end

    // The third sample is taken live; the bit is decided by 2-of-3 vote.
    always_comb begin
        bit_ready_s = (samp_cnt_r == 2'd2);
        bit_dec_s   = maj3(samp0_r, samp1_r, comp_sync_r);
    end
`else
    // One synced comparator sample decides each bit.
    always_comb begin
        bit_ready_s = 1'b1;
        bit_dec_s   = comp_sync_r;
    end
`endif

    // Calibration sequencer with registered codes and status.
    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            state_r   <= ST_IDLE;
            idx_r     <= IDX_MSB;
            cnt_r     <= '0;
            pd_code_r <= CODE_MID;
            pu_code_r <= CODE_MID;
            busy_r    <= 1'b0;
            sel_pu_r  <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else if (busy_r && !i_cal_en) begin
            // Abort: the codes keep their partial values, and the status reports an error.
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            sel_pu_r <= 1'b0;
            done_r   <= 1'b0;
            error_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_edge_s) begin
                        state_r   <= ST_PD_SET;
                        idx_r     <= IDX_MSB;
                        pd_code_r <= '0;
                        done_r    <= 1'b0;
                        error_r   <= 1'b0;
                        busy_r    <= 1'b1;
                        sel_pu_r  <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PD_SET: begin
                    pd_code_r[idx_r] <= 1'b1;
                    cnt_r            <= cnt_load_s;
                    state_r          <= ST_PD_WAIT;
                end
                ST_PD_WAIT: begin
                    if (cnt_r == '0) begin
                        state_r <= ST_PD_SAMP;
                    end else begin
                        cnt_r <= cnt_r - SETTLE_W'(1);
                    end
                end
                ST_PD_SAMP: begin
                    if (bit_ready_s) begin
                        pd_code_r[idx_r] <= bit_dec_s;
                        if (idx_r == '0) begin
                            idx_r     <= IDX_MSB;
                            pu_code_r <= '0;
                            sel_pu_r  <= 1'b1;
                            state_r   <= ST_PU_SET;
                        end else begin
                            idx_r   <= idx_r - IDX_W'(1);
                            state_r <= ST_PD_SET;
                        end
                    end else begin
                        state_r <= ST_PD_SAMP;
                    end
                end
                ST_PU_SET: begin
                    pu_code_r[idx_r] <= 1'b1;
                    cnt_r            <= cnt_load_s;
                    state_r          <= ST_PU_WAIT;
                end
                ST_PU_WAIT: begin
                    if (cnt_r == '0) begin
                        state_r <= ST_PU_SAMP;
                    end else begin
                        cnt_r <= cnt_r - SETTLE_W'(1);
                    end
                end
                ST_PU_SAMP: begin
                    if (bit_ready_s) begin
                        pu_code_r[idx_r] <= bit_dec_s;
                        if (idx_r == '0) begin
                            idx_r    <= IDX_MSB;
                            busy_r   <= 1'b0;
                            sel_pu_r <= 1'b0;
                            state_r  <= ST_DONE;
                        end else begin
                            idx_r   <= idx_r - IDX_W'(1);
                            state_r <= ST_PU_SET;
                        end
                    end else begin
                        state_r <= ST_PU_SAMP;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    error_r <= code_saturated(pd_code_r) | code_saturated(pu_code_r);
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    sel_pu_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_cal_active = busy_r;
    assign o_sel_pu     = sel_pu_r;
    assign o_pd_code    = pd_code_r;
    assign o_pu_code    = pu_code_r;
    assign o_sta        = {error_r, done_r, busy_r, pu_code_r, pd_code_r};

endmodule

// File: tb/tb_ddr_cmn_zqcal_ctrl.sv
// Scoreboard bench for ddr_cmn_zqcal_ctrl: the stimulus pushes expected
// results, and the monitor pops and compares them when the DUT finishes or aborts.
module tb_ddr_cmn_zqcal_ctrl;

`ifdef DDR_ZQCAL_MAJORITY_EN
    localparam int PB = 4;
`else
    localparam int PB = 2;
`endif
    localparam int LAT4 = 2 * 6 * (4 + PB) + 1;   // 73 in the default build
    localparam int LAT2 = 2 * 6 * (2 + PB) + 1;   // 49 in the default build

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start;
    logic [7:0]  settle;
    logic        comp;
    logic        cal_active;
    logic        sel_pu;
    logic [5:0]  pd_code;
    logic [5:0]  pu_code;
    logic [14:0] sta;

    int pd_tgt = 37;
    int pu_tgt = 20;

    typedef struct {
        bit         is_abort;
        logic [5:0] pd;
        logic [5:0] pu;
        logic       err;
        int         ref_cyc;
        int         lat;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   events = 0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;

    ddr_cmn_zqcal_ctrl #(.CODE_W(6), .SETTLE_W(8)) dut (
        .i_hclk       (clk),
        .i_hreset     (rst),
        .i_cal_en     (en),
        .i_cal_start  (start),
        .i_settle_cyc (settle),
        .i_comp       (comp),
        .o_cal_active (cal_active),
        .o_sel_pu     (sel_pu),
        .o_pd_code    (pd_code),
        .o_pu_code    (pu_code),
        .o_sta        (sta)
    );

    // Comparator model: the output is high while the active trial code is at or below the target.
    assign comp = sel_pu ? ((int'(pu_code) <= pu_tgt) ? 1'b1 : 1'b0)
                         : ((int'(pd_code) <= pd_tgt) ? 1'b1 : 1'b0);

    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp_v);
        end
    endtask

    // Monitor: reacts to a done rising edge or to an abort (busy falls while error is set).
    always @(negedge clk) begin
        if (rst) begin
            prev_busy <= 1'b0;
            prev_done <= 1'b0;
        end else begin
            if ((sta[13] && !prev_done) || (prev_busy && !sta[12] && sta[14] && !sta[13])) begin
                if (q.size() == 0) begin
                    check("unexpected_event", 1, 0);
                end else begin
                    e = q.pop_front();
                    check(e.is_abort ? "abort_done" : "done_flag", int'(sta[13]), e.is_abort ? 0 : 1);
                    check("pd_code", int'(pd_code), int'(e.pd));
                    check("pu_code", int'(pu_code), int'(e.pu));
                    check("error", int'(sta[14]), int'(e.err));
                    check("sta_codes", int'(sta[11:0]), int'({e.pu, e.pd}));
                    check("latency", cyc - e.ref_cyc, e.lat);
                end
                events <= events + 1;
            end
            prev_busy <= sta[12];
            prev_done <= sta[13];
        end
    end

    task automatic wait_event(input int n0, input int budget);
        int k;
        k = 0;
        while (events <= n0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (events <= n0) check("timeout", 0, 1);
    endtask

    task automatic run_cal(input int pdt, input int put, input logic [7:0] s,
                           input logic [5:0] epd, input logic [5:0] epu,
                           input logic eerr, input int elat);
        exp_t x;
        int   n0;
        pd_tgt = pdt;
        pu_tgt = put;
        settle = s;
        @(negedge clk);
        n0 = events;
        x.is_abort = 1'b0; x.pd = epd; x.pu = epu; x.err = eerr;
        x.ref_cyc = cyc + 1; x.lat = elat;
        q.push_back(x);
        start = 1'b1;
        wait_event(n0, 3000);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        exp_t x;
        int   n0;
        int   busy_cnt;
        int   k;
        rst = 1'b1; en = 1'b0; start = 1'b0; settle = 8'd4;
        repeat (3) @(negedge clk);
        check("rst_sta", int'(sta), 2080);
        check("rst_active", int'(cal_active), 0);
        check("rst_sel_pu", int'(sel_pu), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_sta", int'(sta), 2080);
        en = 1'b1;

        // Nominal calibration.
        run_cal(37, 20, 8'd4, 6'd37, 6'd20, 1'b0, LAT4);

        // A start toggle while busy is ignored.
        pd_tgt = 37; pu_tgt = 20; settle = 8'd4;
        @(negedge clk);
        n0 = events;
        x.is_abort = 1'b0; x.pd = 6'd37; x.pu = 6'd20; x.err = 1'b0;
        x.ref_cyc = cyc + 1; x.lat = LAT4;
        q.push_back(x);
        start = 1'b1;
        repeat (20) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        wait_event(n0, 3000);
        // Holding start high after done must not restart.
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cal_active) busy_cnt++;
        end
        check("no_restart_held", busy_cnt, 0);
        start = 1'b0;

        // Saturation cases.
        run_cal(-1, 20, 8'd4, 6'd0, 6'd20, 1'b1, LAT4);
        run_cal(63, 63, 8'd4, 6'd63, 6'd63, 1'b1, LAT4);

        // Settle values below 2 are clamped to 2.
        run_cal(37, 20, 8'd0, 6'd37, 6'd20, 1'b0, LAT2);
        run_cal(37, 20, 8'd1, 6'd37, 6'd20, 1'b0, LAT2);

        // Abort during the first pull-up wait.
        pd_tgt = 37; pu_tgt = 20; settle = 8'd4;
        @(negedge clk);
        n0 = events;
        start = 1'b1;
        k = 0;
        while (!sel_pu && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!sel_pu) check("timeout_sel_pu", 0, 1);
        repeat (2) @(negedge clk);
        x.is_abort = 1'b1; x.pd = 6'd37; x.pu = 6'd32; x.err = 1'b1;
        x.ref_cyc = cyc + 1; x.lat = 0;
        q.push_back(x);
        en = 1'b0;
        wait_event(n0, 50);
        repeat (3) @(negedge clk);
        check("abort_busy", int'(sta[12]), 0);
        check("abort_done_low", int'(sta[13]), 0);
        start = 1'b0;
        en = 1'b1;

        // Asynchronous reset in the middle of the pull-down phase.
        @(negedge clk);
        start = 1'b1;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", int'(cal_active), 1);
        q.delete();
        #2 rst = 1'b1;
        #1;
        check("async_rst_sta", int'(sta), 2080);
        check("async_rst_active", int'(cal_active), 0);
        check("async_rst_sel", int'(sel_pu), 0);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", int'(cal_active), 0);
        run_cal(37, 20, 8'd4, 6'd37, 6'd20, 1'b0, LAT4);

        repeat (5) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_cmn_zqcal_ctrl.md
Name: ddr_cmn_zqcal_ctrl

Overview:
- Sequential ZQ calibration controller in the common (CMN) block.
- Consumes the ZQ calibration config fields from the CMN CSR block: enable, start, settle count.
- Runs a successive-approximation (SAR) search, first on the pull-down driver code, then on the pull-up driver code, using the analog ZQ comparator output.
- Produces the driver codes for the analog ZQ macro, plus done/busy/error/code status that feeds the CSR ZQCAL status register.

Parameters:
- CODE_W, 6, width of the pull-down and pull-up driver codes.
- SETTLE_W, 8, width of the settle-cycle count input.

Ports:
- i_hclk  input  1  CSR/ahb clock, the only clock.
- i_hreset  input  1  asynchronous, active-high reset.
- i_cal_en  input  1  calibration enable (CSR cfg bit). Low aborts any calibration in progress.
- i_cal_start  input  1  start request (CSR cfg bit). Only a rising edge is acted on.
- i_settle_cyc  input  SETTLE_W  wait cycles after each trial code, before sampling.
- i_comp  input  1  analog comparator output, asynchronous.
- o_cal_active  output  1  enables the analog ZQ comparator/reference while busy.
- o_sel_pu  output  1  0 = pull-down phase, 1 = pull-up phase.
- o_pd_code  output  CODE_W  pull-down driver code to the analog macro.
- o_pu_code  output  CODE_W  pull-up driver code to the analog macro.
- o_sta  output  2*CODE_W+3  status to CSR, packed as {error, done, busy, pu_code, pd_code}.

Behaviour:
- Reset and clocking:
  - Single clock i_hclk. Asynchronous, active-high reset i_hreset.
  - Reset values: all outputs 0, except o_pd_code and o_pu_code, which reset to 1 followed by CODE_W-1 zeros (mid-scale).
- Comparator synchroniser:
  - i_comp passes through a 2-flop synchroniser before use.
  - Effective settle count S = max(i_settle_cyc, 2), so the synchroniser latency is always covered.
- Start condition:
  - i_cal_start is registered once. A start edge is (start & ~start_q & i_cal_en).
  - Edges seen while busy are ignored.
- FSM states: IDLE, PD_SET, PD_WAIT, PD_SAMP, PU_SET, PU_WAIT, PU_SAMP, DONE.
  - IDLE: start edge -> PD_SET. On that cycle: bit index = CODE_W-1, pd_code = 0, done = 0, error = 0.
  - PD_SET (1 cycle): set pd_code[idx] = 1; settle counter = S-1 -> PD_WAIT.
  - PD_WAIT (S cycles): decrement the counter; at 0 -> PD_SAMP.
  - PD_SAMP (1 cycle):
    - If synced comp = 0, clear pd_code[idx]; if comp = 1, keep it.
    - If idx = 0: idx = CODE_W-1, pu_code = 0 -> PU_SET. Otherwise idx-- -> PD_SET.
  - PU_SET / PU_WAIT / PU_SAMP: identical to the pull-down phase, applied to pu_code. After bit 0 -> DONE.
  - DONE (1 cycle): done = 1; error = 1 if either final code is all-zeros or all-ones (saturation) -> IDLE.
- Busy and phase select:
  - busy = 1 in every state except IDLE and DONE.
  - o_cal_active = busy.
  - o_sel_pu = 1 only in the PU_* states.
- Latency: each bit takes S+2 cycles, so done is set 2*CODE_W*(S+2)+1 cycles after the cycle that detects the start edge.
- done and error are sticky; both clear on the next accepted start edge.
- Abort:
  - i_cal_en low in any busy state -> IDLE on the next edge.
  - Codes hold their last values; done = 0; error = 1.
- Hold: codes never change outside PD_* or PU_* states.
- Change of i_settle_cyc while busy: the new value takes effect at the next *_SET state.

Optional Feature:
DDR_ZQCAL_MAJORITY_EN
- Defined:
  - Each *_SAMP state becomes 3 cycles, taking three consecutive synced comp samples.
  - The bit decision is the majority of the three samples.
  - Each bit takes S+4 cycles.
- Undefined: single-sample decision as specified above.

Test Plan:
- Comparator model comp = (trial_code <= 6'd37) for PD and (trial_code <= 6'd20) for PU; S=4; start edge -> pd_code=37, pu_code=20, done=1, error=0, done asserted 73 cycles after edge detect.
- Model target 0 for PD (comp always 0) -> pd_code=0, error=1; target 63 (comp always 1) -> code 63, error=1.
- i_settle_cyc=0 -> treated as 2; total latency 2*6*4+1=49 cycles; codes still correct.
- Drop i_cal_en during PU_WAIT -> IDLE next cycle, busy=0, done=0, error=1, pd_code retains its calibrated value.
- Second start edge while busy -> ignored, final codes and latency unchanged; start held high after done -> no restart until low-then-high.
- Assert i_hreset mid-PD phase -> all outputs 0, codes = 6'b100000 immediately (async), FSM in IDLE.
